// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 exception constants: exception codes, CP0 register addresses,
// status/cause field positions, MEM exception flag bits and the blanking FSM states.
package exc_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b0;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_MSB     = 15;
  localparam int IM_LSB     = 8;
  localparam int IP_MSB     = 15;
  localparam int IP_LSB     = 8;

  localparam int FLAG_IF_ADEL  = 0;
  localparam int FLAG_RI       = 1;
  localparam int FLAG_OV       = 2;
  localparam int FLAG_SYS      = 3;
  localparam int FLAG_BP       = 4;
  localparam int FLAG_ERET     = 5;
  localparam int FLAG_MEM_ADEL = 6;
  localparam int FLAG_MEM_ADES = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } blank_state_e;

  // Software interrupts IP[1:0] bypass the IE/EXL gate, as the equation is written.
  function automatic logic irq_pending(input logic ie, input logic exl,
                                       input logic [7:0] im, input logic [7:0] ip);
    return (ie & ~exl & (|(im[7:2] & ip[7:2]))) | (|(im[1:0] & ip[1:0]));
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with MTC0 snoop; timer_int_o registered, sticky until Compare write.
// Latency: set on the edge after Count==Compare; no backpressure.
module cp0_timer
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic        timer_int_o
);

  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          timer_int_q, timer_int_d;
  logic          wr_count, wr_compare;

  assign wr_count   = we_i && (waddr_i == CP0_COUNT);
  assign wr_compare = we_i && (waddr_i == CP0_COMPARE);

  always_comb begin
    presc_d     = presc_q;
    count_d     = count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;

    if (wr_count) begin
      presc_d = '0;
      count_d = wdata_i;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // A Compare write on the match cycle wins: the interrupt stays clear.
    if (wr_compare) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else if (count_q == compare_q) begin
      timer_int_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i == RST_ENABLE) begin
      presc_q     <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt resolver feeding CP0; exccode/pc/badaddr are combinational
// (zero latency), int_o lags ext_int_i by 2 cycles; no backpressure.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_DIV = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [5:0]  ext_int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [7:0]  mem_exc_i,
  input  logic [31:0] if_badaddr_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  output logic [5:0]  int_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [31:0] badaddr_o,
  output logic        timer_int_o
);

  logic [5:0]   ext_sync1_q, ext_sync2_q;
  logic         timer_int;
  logic         rst_act, pend, blank;
  logic [4:0]   code_res;
  logic [31:0]  bad_res;
  blank_state_e state_q;
  logic         unused_fields;

  assign unused_fields = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      ext_sync1_q <= '0;
      ext_sync2_q <= '0;
    end else begin
      ext_sync1_q <= ext_int_i;
      ext_sync2_q <= ext_sync1_q;
    end
  end

  cp0_timer #(
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .clk_i       (cpu_clk_50M),
    .rst_n_i     (cpu_rst_n),
    .we_i        (cp0_we_i),
    .waddr_i     (cp0_waddr_i),
    .wdata_i     (cp0_wdata_i),
    .timer_int_o (timer_int)
  );

  assign pend = irq_pending(status_i[STATUS_IE], status_i[STATUS_EXL],
                            status_i[IM_MSB:IM_LSB], cause_i[IP_MSB:IP_LSB]);

  always_comb begin
    code_res = EXC_NONE;
    bad_res  = '0;
    if (mem_valid_i && pend) begin
      code_res = EXC_INT;
    end else if (mem_exc_i[FLAG_IF_ADEL]) begin
      code_res = EXC_ADEL;
      bad_res  = if_badaddr_i;
    end else if (mem_exc_i[FLAG_RI]) begin
      code_res = EXC_RI;
    end else if (mem_exc_i[FLAG_OV]) begin
      code_res = EXC_OV;
    end else if (mem_exc_i[FLAG_SYS]) begin
      code_res = EXC_SYS;
    end else if (mem_exc_i[FLAG_BP]) begin
      code_res = EXC_BP;
    end else if (mem_exc_i[FLAG_ERET]) begin
      code_res = EXC_ERET;
    end else if (mem_exc_i[FLAG_MEM_ADEL]) begin
      code_res = EXC_ADEL;
      bad_res  = mem_badaddr_i;
    end else if (mem_exc_i[FLAG_MEM_ADES]) begin
      code_res = EXC_ADES;
      bad_res  = mem_badaddr_i;
    end
  end

  // One blanked cycle after any reported exception hides the flushed wrong-path instruction.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (code_res != EXC_NONE) state_q <= ST_BLANK;
        ST_BLANK: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign rst_act     = (cpu_rst_n == RST_ENABLE);
  assign blank       = (state_q == ST_BLANK);
  assign exccode_o   = (rst_act || blank) ? EXC_NONE : code_res;
  assign badaddr_o   = (rst_act || blank) ? 32'd0 : bad_res;
  assign pc_o        = rst_act ? 32'd0 : mem_pc_i;
  assign in_delay_o  = rst_act ? 1'b0 : mem_in_delay_i;
  assign int_o       = rst_act ? 6'd0 : {ext_sync2_q[5] | timer_int, ext_sync2_q[4:0]};
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_exc_ctrl;
  localparam int DIV = 2;
  localparam logic [4:0] C_INT = 5'h00, C_ADEL = 5'h04, C_ADES = 5'h05, C_SYS = 5'h08;
  localparam logic [4:0] C_BP = 5'h09, C_RI = 5'h0a, C_OV = 5'h0c, C_NONE = 5'h10, C_ERET = 5'h11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  ext;
  logic        valid;
  logic [31:0] pc;
  logic        in_delay;
  logic [7:0]  flags;
  logic [31:0] if_bad, mem_bad;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] status, cause;
  logic [5:0]  int_o;
  logic [4:0]  exccode_o;
  logic [31:0] pc_o, badaddr_o;
  logic        in_delay_o, timer_int_o;

  int n_chk = 0;
  int n_fail = 0;

  exc_ctrl #(.TIMER_DIV(DIV)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .ext_int_i(ext), .mem_valid_i(valid),
    .mem_pc_i(pc), .mem_in_delay_i(in_delay), .mem_exc_i(flags),
    .if_badaddr_i(if_bad), .mem_badaddr_i(mem_bad),
    .cp0_we_i(we), .cp0_waddr_i(waddr), .cp0_wdata_i(wdata),
    .status_i(status), .cause_i(cause),
    .int_o(int_o), .exccode_o(exccode_o), .pc_o(pc_o), .in_delay_o(in_delay_o),
    .badaddr_o(badaddr_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [5:0]  m_h1, m_h2;          // ext_int as sampled one and two edges ago
  logic [31:0] m_base, m_cmp;       // Count = base + edges_since_load / DIV
  int          m_cyc;
  logic        m_tint;
  logic [4:0]  m_prev = C_NONE;     // code reported in the previous cycle
  logic [4:0]  pr_code [8] = '{C_ADEL, C_RI, C_OV, C_SYS, C_BP, C_ERET, C_ADEL, C_ADES};

  function automatic logic [31:0] count_now();
    return m_base + 32'(m_cyc / DIV);
  endfunction

  function automatic void expect_out(output logic [4:0] code, output logic [31:0] bad);
    logic pend;
    logic found;
    code = C_NONE;
    bad  = 32'd0;
    if (!rst_n || m_prev != C_NONE) return;
    pend = (status[0] && !status[1] && ((status[15:10] & cause[15:10]) != 0)) ||
           ((status[9:8] & cause[9:8]) != 0);
    found = 1'b0;
    if (valid && pend) begin
      code = C_INT;
      found = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (!found && flags[i]) begin
        code = pr_code[i];
        found = 1'b1;
        if (i == 0) bad = if_bad;
        else if (i >= 6) bad = mem_bad;
      end
    end
  endfunction

  logic [4:0]  u_code;
  logic [31:0] u_bad, u_cnt;
  always @(posedge clk) begin
    expect_out(u_code, u_bad);
    u_cnt = count_now();
    if (!rst_n) begin
      m_valid = 1'b1;
      m_h1 = '0; m_h2 = '0;
      m_base = '0; m_cyc = 0; m_cmp = '0; m_tint = 1'b0;
      m_prev = C_NONE;
    end else begin
      m_prev = u_code;
      m_h2 = m_h1;
      m_h1 = ext;
      if (we && waddr == 5'd11) m_tint = 1'b0;
      else if (u_cnt == m_cmp) m_tint = 1'b1;
      if (we && waddr == 5'd11) m_cmp = wdata;
      if (we && waddr == 5'd9) begin
        m_base = wdata;
        m_cyc  = 0;
      end else begin
        m_cyc++;
      end
    end
  end

  logic [4:0]  c_code;
  logic [31:0] c_bad;
  always @(negedge clk) begin
    if (m_valid) begin
      expect_out(c_code, c_bad);
      chk("exccode", 32'(exccode_o), 32'(c_code));
      chk("badaddr", badaddr_o, c_bad);
      chk("pc", pc_o, rst_n ? pc : 32'd0);
      chk("in_delay", 32'(in_delay_o), rst_n ? 32'(in_delay) : 32'd0);
      chk("int", 32'(int_o), rst_n ? 32'({m_h2[5] | m_tint, m_h2[4:0]}) : 32'd0);
      chk("timer_int", 32'(timer_int_o), 32'(m_tint));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ext = '0; valid = 1'b0; pc = '0; in_delay = 1'b0; flags = '0;
    if_bad = '0; mem_bad = '0; we = 1'b0; waddr = '0; wdata = '0;
    status = '0; cause = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  int n;
  initial begin
    clear_in();
    rst_n = 1'b0;
    pc = 32'hdead_beef;
    in_delay = 1'b1;
    repeat (3) tick();
    #1;
    chk("reset_code", 32'(exccode_o), 32'(C_NONE));
    chk("reset_pc", pc_o, 32'd0);
    chk("reset_int", 32'(int_o), 32'd0);
    chk("reset_delay", 32'(in_delay_o), 32'd0);
    chk("reset_timer", 32'(timer_int_o), 32'd0);
    rst_n = 1'b1;
    clear_in();
    tick();

    // priority: ri beats ov and mem_ades, then one blanked cycle
    valid = 1'b1; flags = 8'b1000_0110; pc = 32'h100; mem_bad = 32'h44;
    #1;
    chk("prio_code", 32'(exccode_o), 32'(C_RI));
    chk("prio_bad", badaddr_o, 32'd0);
    tick();
    #1;
    chk("blank_code", 32'(exccode_o), 32'(C_NONE));
    tick();
    flags = '0;
    tick();

    // store alignment
    flags = 8'h80; mem_bad = 32'h8000_1002; pc = 32'h2468;
    #1;
    chk("ades_code", 32'(exccode_o), 32'(C_ADES));
    chk("ades_bad", badaddr_o, 32'h8000_1002);
    chk("ades_pc", pc_o, 32'h2468);
    tick();
    flags = '0;
    tick();

    // masking
    ext = 6'b000001; cause = 32'h0000_0400; status = 32'h0000_0403; valid = 1'b1;
    #1;
    chk("mask_exl", 32'(exccode_o), 32'(C_NONE));
    tick();
    status = 32'h0000_0401; valid = 1'b0;
    #1;
    chk("mask_bubble", 32'(exccode_o), 32'(C_NONE));
    tick();
    chk("ext_sync", 32'(int_o[4:0]), 32'd1);
    valid = 1'b1;
    #1;
    chk("int_taken", 32'(exccode_o), 32'(C_INT));
    tick();
    status = '0; cause = '0; ext = '0;
    tick(); tick();

    // interrupt plus sys: INT wins
    status = 32'h0000_0401; cause = 32'h0000_0400; flags = 8'h08;
    #1;
    chk("int_sys", 32'(exccode_o), 32'(C_INT));
    tick();
    clear_in();
    tick();

    // timer: Compare=5, Count=0 -> rises 11 cycles later
    mtc0(5'd9, 32'h1000);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (n == 0) begin
        tick();
        if (timer_int_o) n = i;
      end
    end
    chk("timer_delay", 32'(n), 32'd11);
    chk("timer_int5", 32'(int_o[5]), 32'd1);
    mtc0(5'd11, 32'h100);
    chk("timer_clear", 32'(timer_int_o), 32'd0);

    // Compare write on the match cycle keeps timer_int low
    mtc0(5'd9, 32'h1000);
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    repeat (6) tick();
    mtc0(5'd11, 32'd3);
    chk("cmp_wins", 32'(timer_int_o), 32'd0);
    tick();
    chk("cmp_rematch", 32'(timer_int_o), 32'd1);

    // reset mid-operation while blanked with the timer pending
    valid = 1'b1; flags = 8'h08;
    tick();
    rst_n = 1'b0; flags = '0; pc = 32'habc; in_delay = 1'b1; mem_bad = 32'h55;
    #1;
    chk("rst_mid_code", 32'(exccode_o), 32'(C_NONE));
    chk("rst_mid_pc", pc_o, 32'd0);
    chk("rst_mid_int", 32'(int_o), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_after_timer", 32'(timer_int_o), 32'd0);
    chk("rst_after_code", 32'(exccode_o), 32'(C_NONE));
    tick();
    flags = 8'h08;
    #1;
    chk("rst_after_idle", 32'(exccode_o), 32'(C_SYS));
    tick();
    clear_in();
    tick();

    // randomized traffic, checked by the per-cycle compare process
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) ext = 6'($urandom);
      valid = ($urandom_range(0, 3) != 0);
      flags = '0;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) flags[b] = 1'b1;
      pc = $urandom; in_delay = 1'($urandom); if_bad = $urandom; mem_bad = $urandom;
      status = $urandom;
      cause = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hffff_00ff);
      we = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: begin
          waddr = 5'd11;
          wdata = count_now() + 32'($urandom_range(0, 8));
        end
        1: begin
          waddr = 5'd9;
          wdata = ($urandom_range(0, 3) == 0) ? 32'hffff_fffe : 32'($urandom_range(0, 20));
        end
        default: begin
          waddr = 5'($urandom);
          wdata = $urandom;
        end
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt source unit for the MEM stage. Collects per-instruction exception flags from the pipeline, the external hardware interrupt lines and its own Count/Compare timer, and resolves them into the single prioritised exception code, victim PC, delay-slot flag and bad address consumed by the CP0 register file. It is the producer side of the CP0 exception interface: CP0 acts on `exccode_o`, and this block generates it.

## Interface
- `TIMER_DIV`, default 2: Count increments once every `TIMER_DIV` cycles.
- `cpu_clk_50M  in  1`: clock.
- `cpu_rst_n  in  1`: reset, synchronous, active-low (`RST_ENABLE` = 0).
- `ext_int_i  in  6`: asynchronous hardware interrupt lines HW5..HW0.
- `mem_valid_i  in  1`: MEM holds a real instruction this cycle, not a bubble.
- `mem_pc_i  in  32`: PC of the MEM instruction.
- `mem_in_delay_i  in  1`: MEM instruction is in a delay slot.
- `mem_exc_i  in  8`: flags, one-hot or multi-hot: [0] if_adel, [1] ri, [2] ov, [3] sys, [4] bp, [5] eret, [6] mem_adel, [7] mem_ades.
- `if_badaddr_i  in  32`: fetch PC that caused if_adel.
- `mem_badaddr_i  in  32`: data address that caused mem_adel or mem_ades.
- `cp0_we_i  in  1`, `cp0_waddr_i  in  5`, `cp0_wdata_i  in  32`: snooped MTC0 write port.
- `status_i  in  32`, `cause_i  in  32`: from CP0. Fields used: IE=[0], EXL=[1], IM=[15:8]; cause IP=[15:8].
- `int_o  out  6`: to CP0 `int_i`, which becomes cause[15:10].
- `exccode_o  out  5`: to CP0 `exccode_i`.
- `pc_o  out  32`, `in_delay_o  out  1`, `badaddr_o  out  32`: to CP0.
- `timer_int_o  out  1`: timer interrupt pending.

## Operation
- Exception codes, defined as shared constants: INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, OV=0x0c, NONE=0x10, ERET=0x11.
- **External interrupts:** each `ext_int_i` bit passes through a 2-flop synchroniser.
- **Timer:**
  - Count is 32 bits. A prescaler counter counts to `TIMER_DIV-1` and wraps; Count increments by 1 on each wrap, and Count wraps 0xFFFFFFFF→0.
  - When Count equals Compare, `timer_int` is set (sticky).
  - An MTC0 write to Compare (addr 11) loads Compare and clears `timer_int` in the same edge.
  - An MTC0 write to Count (addr 9) loads Count and resets the prescaler. The write takes priority over the increment.
- `int_o = {sync[5] | timer_int, sync[4:0]}`.
- **Interrupt pending:** `pend = IE & ~EXL & |(IM[7:2] & IP[7:2]) | |(IM[1:0] & IP[1:0])`. `pend` is only acted on when `mem_valid_i` = 1.
- **Priority,** highest first: INT, if_adel (ADEL, badaddr = `if_badaddr_i`), RI, OV, SYS, BP, ERET, mem_adel (ADEL, badaddr = `mem_badaddr_i`), mem_ades (ADES, badaddr = `mem_badaddr_i`). If nothing applies, the code is NONE.
- **Blanking FSM:** states IDLE and BLANK.
  - IDLE→BLANK when the resolved code ≠ NONE.
  - BLANK→IDLE unconditionally after 1 cycle.
  - In BLANK, `exccode_o` is forced to NONE, so the flushed wrong-path instruction cannot re-trigger an exception.
- `pc_o` and `in_delay_o` pass `mem_pc_i` and `mem_in_delay_i` through. `badaddr_o` is 0 when the code is not ADEL or ADES.

## Timing
- Outputs `exccode_o`, `pc_o`, `in_delay_o` and `badaddr_o` are combinational from the current MEM inputs and the FSM state, with zero latency, because CP0 flushes in the same cycle.
- External interrupt latency: `ext_int_i` to `int_o` is 2 cycles. CP0 then takes 1 more cycle to reach cause.IP, so the earliest INT code appears 3 cycles after the input changes.
- Timer: `timer_int_o` rises on the edge after Count==Compare is first true.
- Simultaneous events:
  - Compare write and match on the same cycle: the write wins and `timer_int` = 0.
  - Interrupt and a synchronous exception together: INT is reported and the synchronous exception is dropped. The instruction is re-executed after ERET.
- Reset, also when asserted mid-operation:
  - Synchroniser flops, Count, Compare, prescaler and `timer_int` are cleared to 0; FSM goes to IDLE.
  - While reset is low: `exccode_o` = NONE, `int_o` = 0, `pc_o` = 0, `badaddr_o` = 0, `in_delay_o` = 0.

## Structure
- Exception codes, CP0 register addresses (COUNT=9, COMPARE=11) and status/cause bit positions live in the shared defines file, next to the existing `EXC_*` and `CP0_*` constants.
- One sub-module, `cp0_timer`: prescaler, Count, Compare, `timer_int`, and the MTC0 snoop.
- Synchroniser, priority encoder and blanking FSM stay in `exc_ctrl`.

## Test plan
- **Priority:** `mem_exc_i` = 8'b1000_0110 (ri + ov + mem_ades), valid, no interrupt pending → `exccode_o` = 0x0a, `badaddr_o` = 0; next cycle `exccode_o` = 0x10 (blanked).
- **Store alignment:** mem_ades, `mem_badaddr_i` = 0x8000_1002 → `exccode_o` = 0x05, `badaddr_o` = 0x8000_1002, `pc_o` = `mem_pc_i`.
- **Timer:**
  - Set-up: `TIMER_DIV` = 2; write Compare = 5, then Count = 0.
  - Required: `timer_int_o` rises 11 cycles after the Count write. `int_o[5]` = 1.
  - Clear: a Compare write drops `timer_int_o` on the next edge.
- **Masking:** `ext_int_i[0]` = 1 with cause IP2 set by CP0.
  - status = 0x0000_0401 → INT (0x00) when `mem_valid_i` = 1.
  - status = 0x0000_0403 (EXL set) → NONE.
  - `mem_valid_i` = 0 → NONE.
- **Simultaneous events:** Compare write on the match cycle → `timer_int_o` stays 0. Interrupt together with sys → 0x00 reported.
- **Reset mid-operation:** reset low for 1 cycle while in BLANK with the timer pending → next cycle FSM is IDLE, Count = 0, `timer_int_o` = 0, `exccode_o` = 0x10.
